cu_fsm: RTL and testbench
=========================

Name: cu_fsm

Overview:
- Multicycle sequencing state machine for the OTTER RISC-V core; sits beside the combinational control decoder.
- Decides in which cycle the PC, register file, CSR file, instruction register and memory ports may act.
- Adds memory wait-state handshaking and interrupt entry.
- The decoder still selects muxes and ALU function; this block only issues the write/read strobes.

Parameters:
- INIT_CYCLES, 2, number of clock cycles pc_rst stays asserted after reset release (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  ir[6:0]
- func3  in  3  ir[14:12]
- intr  in  1  interrupt request, already gated by mstatus.MIE externally
- mem_rdy  in  1  memory completes current access this cycle (tie 1 for zero-wait memory)
- pc_rst  out  1  force PC to reset vector
- ir_ld  out  1  load instruction register
- pc_write  out  1  PC register write enable
- reg_write  out  1  register file write enable
- mem_rden1  out  1  instruction port read enable
- mem_rden2  out  1  data port read enable
- mem_we2  out  1  data port write enable
- csr_we  out  1  CSR write enable
- int_taken  out  1  interrupt entry: save mepc/mcause, PC←mtvec
- mret_exec  out  1  MRET executing: restore PC←mepc
- state  out  3  debug state code: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4

Behaviour:
- State register and INIT counter are reset asynchronously by rst_n low: state=INIT, counter=INIT_CYCLES-1.
- All outputs are combinational from state, opcode, func3 and mem_rdy. Any strobe not listed for a condition is 0.
- During reset: pc_rst=1, every other strobe 0, state=0.
- INIT:
  - pc_rst=1.
  - Counter decrements each clock.
  - When counter==0, next state is FETCH, so pc_rst is high for exactly INIT_CYCLES clock edges after rst_n rises.
- FETCH:
  - mem_rden1=1 every cycle.
  - On mem_rdy=1: ir_ld=1, next state EXEC.
  - Otherwise stay in FETCH (wait state) with outputs unchanged.
- EXEC, decoded by opcode:
  - LOAD (0000011):
    - mem_rden2=1.
    - On mem_rdy: next state WB.
    - Otherwise stay in EXEC.
    - No pc_write or reg_write in EXEC.
  - STORE (0100011):
    - mem_we2=1 until mem_rdy.
    - In the mem_rdy cycle: pc_write=1, instruction completes.
  - BRANCH (1100011): pc_write=1, complete.
  - LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111), OP_IMM (0010011), OP_RG3 (0110011): pc_write=1, reg_write=1, complete.
  - SYSTEM (1110011):
    - func3=001 (CSRRW): csr_we=1, reg_write=1, pc_write=1.
    - func3=000 (MRET): pc_write=1, mret_exec=1.
    - Other func3: pc_write=1 only.
    - All complete.
  - Any other opcode: pc_write=1 only (treated as NOP), complete.
  - mem_rdy is ignored for non-memory opcodes.
- WB: reg_write=1, pc_write=1, complete.
- Completion: next state is INTR if intr=1 in the completing cycle, else FETCH.
- INTR:
  - int_taken=1, pc_write=1, next state FETCH.
  - intr is ignored while in INTR; an interrupt is never taken twice back-to-back without an instruction in between.
- intr is sampled only in completing cycles. It has no effect during INIT, FETCH, memory wait cycles or INTR. The requester holds intr until serviced.
- Each instruction gets exactly one pc_write pulse; an interrupt entry adds one more.
- Memory strobes (mem_rden1, mem_rden2, mem_we2) are held stable across wait cycles.
- Reset asserted mid-instruction, including during a memory wait: immediate return to INIT, all strobes drop except pc_rst, counter reloads.
- Illegal state codes (5–7) go to INIT on the next clock with all outputs 0.

Test Plan:
- Reset release with INIT_CYCLES=2, mem_rdy=1 → pc_rst high during reset plus 2 edges; state sequence 0,0,1,2; ir_ld pulses in the first FETCH cycle.
- ADDI (opcode 0010011), mem_rdy=1 → FETCH then EXEC; in EXEC pc_write=1, reg_write=1; back to FETCH; 2 cycles per instruction.
- LW with mem_rdy low for 3 EXEC cycles → mem_rden2 high for 4 cycles; then WB with reg_write=1, pc_write=1; no earlier pc_write.
- SW with 1 wait cycle → mem_we2 high 2 cycles; pc_write only in the second; reg_write stays 0.
- intr=1 asserted during a FETCH wait of an OP_RG3 → no action until EXEC completes; then INTR with int_taken=1, pc_write=1; then FETCH.
- CSRRW (1110011, func3=001) → csr_we=1, reg_write=1, pc_write=1.
- MRET (func3=000) → mret_exec=1, pc_write=1, reg_write=0.
- rst_n pulled low mid-load wait → state=0 immediately, mem_rden2=0, pc_rst=1.

Source files
------------

// File: rtl/cu_fsm.sv
// cu_fsm: multicycle sequencer for the OTTER RISC-V core.
// Issues the PC, register file, CSR, IR and memory strobes for each
// instruction phase, with memory wait states and interrupt entry.
// Mux selects and ALU function remain in the combinational decoder.
module cu_fsm #(
    parameter int INIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       intr,
    input  logic       mem_rdy,
    output logic       pc_rst,
    output logic       ir_ld,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       csr_we,
    output logic       int_taken,
    output logic       mret_exec,
    output logic [2:0] state
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INIT_CYCLES - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_RG3    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             done;

    // Strobe decode and next-state selection for the current phase
    always_comb begin
        pc_rst    = 1'b0;
        ir_ld     = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        done      = 1'b0;
        state_nxt = state_q;
        case (state_q)
            ST_INIT: begin
                pc_rst = 1'b1;
                if (cnt_q == '0)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (mem_rdy) begin
                    ir_ld     = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LOAD: begin
                        // Register write-back happens in WB once data is valid
                        mem_rden2 = 1'b1;
                        if (mem_rdy)
                            state_nxt = ST_WB;
                    end
                    OP_STORE: begin
                        mem_we2 = 1'b1;
                        if (mem_rdy) begin
                            pc_write = 1'b1;
                            done     = 1'b1;
                        end
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        done     = 1'b1;
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        done      = 1'b1;
                    end
                    OP_SYSTEM: begin
                        pc_write = 1'b1;
                        done     = 1'b1;
                        if (func3 == F3_CSRRW) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end else if (func3 == F3_MRET) begin
                            mret_exec = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcodes retire as a NOP
                        pc_write = 1'b1;
                        done     = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                done      = 1'b1;
            end
            ST_INTR: begin
                // intr deliberately ignored here so entry cannot repeat back-to-back
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: begin
                // Corrupted state code: drive nothing, recover through INIT
                state_nxt = ST_INIT;
            end
        endcase
        if (done)
            state_nxt = intr ? ST_INTR : ST_FETCH;
    end

    // State register and INIT hold-off counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_LOAD;
        end else begin
            state_q <= state_nxt;
            if (state_q == ST_INIT) begin
                if (cnt_q != '0)
                    cnt_q <= cnt_q - 1'b1;
            end else begin
                // Keep the count primed so any later entry to INIT gets the full hold
                cnt_q <= CNT_LOAD;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: walks reset, fetch, ALU, load/store wait
// states, interrupt entry, CSR/MRET and a mid-instruction reset.
module tb_cu_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       intr;
    logic       mem_rdy;
    logic       pc_rst, ir_ld, pc_write, reg_write, mem_rden1, mem_rden2;
    logic       mem_we2, csr_we, int_taken, mret_exec;
    logic [2:0] state;

    int nvec = 0;
    int nmis = 0;

    // Strobe masks in the order {pc_rst, ir_ld, pc_write, reg_write,
    // mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec}
    localparam logic [9:0] NONE = 10'b0000000000;
    localparam logic [9:0] PR   = 10'b1000000000;
    localparam logic [9:0] IL   = 10'b0100000000;
    localparam logic [9:0] PW   = 10'b0010000000;
    localparam logic [9:0] RW   = 10'b0001000000;
    localparam logic [9:0] R1   = 10'b0000100000;
    localparam logic [9:0] R2   = 10'b0000010000;
    localparam logic [9:0] WE   = 10'b0000001000;
    localparam logic [9:0] CW   = 10'b0000000100;
    localparam logic [9:0] IT   = 10'b0000000010;
    localparam logic [9:0] MR   = 10'b0000000001;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] RG3    = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] BOGUS  = 7'b0000000;

    cu_fsm #(.INIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .func3     (func3),
        .intr      (intr),
        .mem_rdy   (mem_rdy),
        .pc_rst    (pc_rst),
        .ir_ld     (ir_ld),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .mem_rden1 (mem_rden1),
        .mem_rden2 (mem_rden2),
        .mem_we2   (mem_we2),
        .csr_we    (csr_we),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] s, input logic [2:0] st);
        logic [12:0] obs;
        logic [12:0] expv;
        obs  = {pc_rst, ir_ld, pc_write, reg_write, mem_rden1, mem_rden2,
                mem_we2, csr_we, int_taken, mret_exec, state};
        expv = {s, st};
        nvec++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s: observed strobes=%b state=%0d, expected strobes=%b state=%0d",
                   tag, obs[12:3], obs[2:0], expv[12:3], expv[2:0]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        opcode  = ADDI;
        func3   = 3'b000;
        intr    = 1'b0;
        mem_rdy = 1'b1;

        // Held in reset
        #12;
        chk("reset", PR, 3'd0);
        #1 rst_n = 1'b1;

        // INIT for two edges, then FETCH, then ADDI
        cyc(); #1 chk("init_hold", PR, 3'd0);
        cyc(); #1 chk("fetch_first", R1 | IL, 3'd1);
        cyc(); #1 chk("addi_exec", PW | RW, 3'd2);

        // LW with three wait cycles
        cyc(); opcode = LOAD; #1 chk("lw_fetch", R1 | IL, 3'd1);
        cyc(); mem_rdy = 1'b0; #1 chk("lw_wait1", R2, 3'd2);
        cyc(); #1 chk("lw_wait2", R2, 3'd2);
        cyc(); #1 chk("lw_wait3", R2, 3'd2);
        cyc(); mem_rdy = 1'b1; #1 chk("lw_rdy", R2, 3'd2);
        cyc(); #1 chk("lw_wb", RW | PW, 3'd3);

        // SW with one wait cycle
        cyc(); opcode = STORE; #1 chk("sw_fetch", R1 | IL, 3'd1);
        cyc(); mem_rdy = 1'b0; #1 chk("sw_wait", WE, 3'd2);
        cyc(); mem_rdy = 1'b1; #1 chk("sw_rdy", WE | PW, 3'd2);

        // OP_RG3 with interrupt raised during a FETCH wait
        cyc(); opcode = RG3; mem_rdy = 1'b0; intr = 1'b1; #1 chk("rg3_fwait1", R1, 3'd1);
        cyc(); #1 chk("rg3_fwait2", R1, 3'd1);
        cyc(); mem_rdy = 1'b1; #1 chk("rg3_fetch", R1 | IL, 3'd1);
        cyc(); #1 chk("rg3_exec", PW | RW, 3'd2);
        cyc(); #1 chk("intr_entry", IT | PW, 3'd4);
        intr = 1'b0;

        // CSRRW
        opcode = SYSTEM; func3 = 3'b001;
        cyc(); #1 chk("csrrw_fetch", R1 | IL, 3'd1);
        cyc(); #1 chk("csrrw_exec", CW | RW | PW, 3'd2);

        // MRET
        cyc(); func3 = 3'b000; #1 chk("mret_fetch", R1 | IL, 3'd1);
        cyc(); #1 chk("mret_exec", MR | PW, 3'd2);

        // Other SYSTEM func3
        cyc(); func3 = 3'b010; #1 chk("sys_fetch", R1 | IL, 3'd1);
        cyc(); #1 chk("sys_other", PW, 3'd2);

        // BRANCH, with interrupt pending at completion
        cyc(); opcode = BRANCH; #1 chk("br_fetch", R1 | IL, 3'd1);
        cyc(); intr = 1'b1; #1 chk("br_exec", PW, 3'd2);
        cyc(); #1 chk("br_intr", IT | PW, 3'd4);
        cyc(); intr = 1'b0; opcode = BOGUS; #1 chk("bogus_fetch", R1 | IL, 3'd1);
        cyc(); #1 chk("bogus_exec", PW, 3'd2);

        // Interrupt held during a load wait is not taken until WB completes
        cyc(); opcode = LOAD; #1 chk("lw2_fetch", R1 | IL, 3'd1);
        cyc(); mem_rdy = 1'b0; intr = 1'b1; #1 chk("lw2_wait", R2, 3'd2);
        cyc(); mem_rdy = 1'b1; #1 chk("lw2_rdy", R2, 3'd2);
        cyc(); #1 chk("lw2_wb", RW | PW, 3'd3);
        cyc(); intr = 1'b0; #1 chk("lw2_intr", IT | PW, 3'd4);

        // Reset pulled during a load wait
        cyc(); #1 chk("lw3_fetch", R1 | IL, 3'd1);
        cyc(); mem_rdy = 1'b0; #1 chk("lw3_wait", R2, 3'd2);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid", PR, 3'd0);
        cyc(); #1 chk("rst_hold", PR, 3'd0);
        rst_n = 1'b1; mem_rdy = 1'b1;
        cyc(); #1 chk("reinit_hold", PR, 3'd0);
        cyc(); #1 chk("refetch", R1 | IL, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
